alu_op_sequencer: RTL and testbench

//  Multi-cycle sequencer for the regfile32x32 -> multiplaxer2x1 -> alu32 datapath.
//  - Accepts one register/immediate ALU command per transaction over a valid/ready handshake.
//  - Drives the regfile read addresses, mux select, immediate and ALU control.
//  - Samples the ALU result and overflow, writes the result back to the regfile, then returns a response.
//  - Replaces hand-driven datapath stimulus; the future decode stage issues commands into it.

---
 rtl/alu_op_sequencer_if.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Signal bundle between alu_op_sequencer and its environment.
// master = command issuer plus regfile/mux/ALU datapath, slave = the sequencer itself.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16,
    parameter int CTRL_W = 4
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_rs;
    logic [ADDR_W-1:0] cmd_rt;
    logic [ADDR_W-1:0] cmd_rd;
    logic [IMM_W-1:0]  cmd_imm;
    logic              cmd_use_imm;
    logic [CTRL_W-1:0] cmd_ctrl;

    // datapath control and observation
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic              mux_slc;
    logic [IMM_W-1:0]  mux_imm;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovf;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_ovf;
    logic [15:0]       op_count;

    modport master (
        output cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_use_imm, cmd_ctrl,
        input  cmd_ready,
        input  rf_raddr1, rf_raddr2, mux_slc, mux_imm, alu_ctrl,
        output alu_out, alu_ovf,
        input  rf_we, rf_waddr, rf_wdata,
        input  rsp_valid, rsp_result, rsp_ovf, op_count,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_use_imm, cmd_ctrl,
        output cmd_ready,
        output rf_raddr1, rf_raddr2, mux_slc, mux_imm, alu_ctrl,
        input  alu_out, alu_ovf,
        output rf_we, rf_waddr, rf_wdata,
        output rsp_valid, rsp_result, rsp_ovf, op_count,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Five-state sequencer (IDLE/READ/EXEC/WB/DONE) driving a regfile -> mux -> ALU datapath.
// Optional macro OVF_TRAP_EN: an overflowing result is not written back to the regfile.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16,
    parameter int CTRL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;
    logic [IMM_W-1:0]  r_imm;
    logic              r_use_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;
    logic [15:0]       r_op_count;

    logic              w_accept;
    logic              w_rsp_take;
    logic              w_cmd_ready;
    logic              w_rf_we;
    logic              w_rsp_valid;
    logic              w_wb_allowed;

    // $zero is never a writeback target; trapped overflows also keep the old value
`ifdef OVF_TRAP_EN
    assign w_wb_allowed = (r_rd != '0) && !r_ovf;
`else
    assign w_wb_allowed = (r_rd != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rsp_take   = 1'b0;
        w_cmd_ready  = 1'b0;
        w_rf_we      = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_WB;
            end
            S_WB: begin
                w_rf_we      = w_wb_allowed;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_rsp_take   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // command fields are held from accept until the next accept so the datapath sees them settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_use_imm  <= 1'b0;
            r_ctrl     <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_rs      <= bus.cmd_rs;
                r_rt      <= bus.cmd_rt;
                r_rd      <= bus.cmd_rd;
                r_imm     <= bus.cmd_imm;
                r_use_imm <= bus.cmd_use_imm;
                r_ctrl    <= bus.cmd_ctrl;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_out;
                r_ovf    <= bus.alu_ovf;
            end
            if (w_rsp_take) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rf_raddr1  = r_rs;
    assign bus.rf_raddr2  = r_rt;
    assign bus.mux_slc    = r_use_imm;
    assign bus.mux_imm    = r_imm;
    assign bus.alu_ctrl   = r_ctrl;
    assign bus.rf_we      = w_rf_we;
    assign bus.rf_waddr   = r_rd;
    assign bus.rf_wdata   = r_result;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_ovf    = r_ovf;
    assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural regfile/mux/ALU environment.
module tb_alu_op_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // environment: 32x32 regfile with $zero hardwired, sign-extending mux, ALU
    logic [31:0] rf [32] = '{default: 32'd0};
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_sum;
    logic [31:0] alu_dif;

    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    always_comb begin
        alu_a   = rf[bus.rf_raddr1];
        alu_b   = bus.mux_slc ? {{16{bus.mux_imm[15]}}, bus.mux_imm} : rf[bus.rf_raddr2];
        alu_sum = alu_a + alu_b;
        alu_dif = alu_a - alu_b;
        bus.alu_ovf = 1'b0;
        case (bus.alu_ctrl)
            4'd0:  bus.alu_out = alu_a & alu_b;
            4'd1:  bus.alu_out = alu_a | alu_b;
            4'd2: begin
                bus.alu_out = alu_sum;
                bus.alu_ovf = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            4'd6: begin
                bus.alu_out = alu_dif;
                bus.alu_ovf = (alu_a[31] != alu_b[31]) && (alu_dif[31] != alu_a[31]);
            end
            4'd7:  bus.alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd12: bus.alu_out = ~(alu_a | alu_b);
            default: bus.alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // returns at the negedge in the middle of READ, with cmd_valid dropped
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic use_imm, input logic [3:0] ctrl);
        int n;
        n = 0;
        bus.cmd_rs      = rs;
        bus.cmd_rt      = rt;
        bus.cmd_rd      = rd;
        bus.cmd_imm     = imm;
        bus.cmd_use_imm = use_imm;
        bus.cmd_ctrl    = ctrl;
        bus.cmd_valid   = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_budget", {31'd0, (n < 20)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        $display("cmd rs=%0d rt=%0d rd=%0d imm=0x%04h use_imm=%0b ctrl=%0d accepted t=%0t",
                 rs, rt, rd, imm, use_imm, ctrl, $time);
    endtask

    // walks READ -> EXEC -> WB -> DONE (+hold cycles) -> IDLE, checking each phase
    task automatic run_flow(input logic [4:0] e_ra1, input logic [4:0] e_ra2, input logic e_slc,
                            input logic [15:0] e_imm, input logic [3:0] e_ctrl,
                            input logic e_we, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                            input logic [31:0] e_res, input logic e_ovf, input logic [15:0] e_cnt,
                            input int hold);
        chk("read_raddr1", bus.rf_raddr1, e_ra1);
        chk("read_raddr2", bus.rf_raddr2, e_ra2);
        chk("read_mux_slc", bus.mux_slc, e_slc);
        chk("read_mux_imm", bus.mux_imm, e_imm);
        chk("read_alu_ctrl", bus.alu_ctrl, e_ctrl);
        chk("read_rf_we", bus.rf_we, 1'b0);
        chk("read_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        chk("exec_rf_we", bus.rf_we, 1'b0);
        chk("exec_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        bus.rsp_ready = (hold == 0);
        chk("wb_rf_we", bus.rf_we, e_we);
        if (e_we) begin
            chk("wb_rf_waddr", bus.rf_waddr, e_waddr);
            chk("wb_rf_wdata", bus.rf_wdata, e_wdata);
        end
        chk("wb_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk("done_rsp_valid", bus.rsp_valid, 1'b1);
        chk("done_rsp_result", bus.rsp_result, e_res);
        chk("done_rsp_ovf", bus.rsp_ovf, e_ovf);
        chk("done_rf_we", bus.rf_we, 1'b0);
        chk("done_mux_slc", bus.mux_slc, e_slc);
        chk("done_mux_imm", bus.mux_imm, e_imm);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
            chk("hold_rsp_result", bus.rsp_result, e_res);
            chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
            chk("hold_raddr1", bus.rf_raddr1, e_ra1);
            chk("hold_alu_ctrl", bus.alu_ctrl, e_ctrl);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
        chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
        chk("idle_op_count", bus.op_count, e_cnt);
        $display("rsp result=0x%08h ovf=%0b op_count=%0d t=%0t", e_res, e_ovf, bus.op_count, $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        pl_en           = 1'b0;
        pl_addr         = 5'd0;
        pl_data         = 32'd0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_rs      = 5'd0;
        bus.cmd_rt      = 5'd0;
        bus.cmd_rd      = 5'd0;
        bus.cmd_imm     = 16'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_ctrl    = 4'd0;
        bus.rsp_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_op_count", bus.op_count, 16'd0);
        chk("rst_raddr1", bus.rf_raddr1, 5'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);

        // 1: 7 + 3 -> $t2
        preload(5'd10, 32'd7);
        preload(5'd11, 32'd3);
        issue(5'd10, 5'd11, 5'd10, 16'd0, 1'b0, 4'd2);
        run_flow(5'd10, 5'd11, 1'b0, 16'd0, 4'd2, 1'b1, 5'd10, 32'd10, 32'd10, 1'b0, 16'd1, 0);
        chk("t1_rf10", rf[10], 32'd10);

        // 2: 10 - imm 5 -> $t1
        issue(5'd10, 5'd0, 5'd9, 16'd5, 1'b1, 4'd6);
        run_flow(5'd10, 5'd0, 1'b1, 16'd5, 4'd6, 1'b1, 5'd9, 32'd5, 32'd5, 1'b0, 16'd2, 0);
        chk("t2_rf9", rf[9], 32'd5);

        // 3: 0x7FFFFFFF + 1 overflows
        preload(5'd8, 32'h7FFF_FFFF);
        preload(5'd9, 32'd1);
`ifdef OVF_TRAP_EN
        issue(5'd8, 5'd9, 5'd8, 16'd0, 1'b0, 4'd2);
        run_flow(5'd8, 5'd9, 1'b0, 16'd0, 4'd2, 1'b0, 5'd8, 32'h8000_0000, 32'h8000_0000, 1'b1, 16'd3, 0);
        chk("t3_rf8_kept", rf[8], 32'h7FFF_FFFF);
`else
        issue(5'd8, 5'd9, 5'd8, 16'd0, 1'b0, 4'd2);
        run_flow(5'd8, 5'd9, 1'b0, 16'd0, 4'd2, 1'b1, 5'd8, 32'h8000_0000, 32'h8000_0000, 1'b1, 16'd3, 0);
        chk("t3_rf8_written", rf[8], 32'h8000_0000);
`endif

        // 4: 10 AND 3 = 2 held in DONE; a competing OR command waits until IDLE
        issue(5'd10, 5'd11, 5'd12, 16'd0, 1'b0, 4'd0);
        bus.cmd_rs      = 5'd11;
        bus.cmd_rt      = 5'd11;
        bus.cmd_rd      = 5'd13;
        bus.cmd_imm     = 16'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_ctrl    = 4'd1;
        bus.cmd_valid   = 1'b1;
        run_flow(5'd10, 5'd11, 1'b0, 16'd0, 4'd0, 1'b1, 5'd12, 32'd2, 32'd2, 1'b0, 16'd4, 6);
        chk("t4a_rf12", rf[12], 32'd2);
        issue(5'd11, 5'd11, 5'd13, 16'd0, 1'b0, 4'd1);
        run_flow(5'd11, 5'd11, 1'b0, 16'd0, 4'd1, 1'b1, 5'd13, 32'd3, 32'd3, 1'b0, 16'd5, 0);
        chk("t4b_rf13", rf[13], 32'd3);

        // 5: SUB into $zero: 10 - 3 = 7, no writeback
        issue(5'd10, 5'd11, 5'd0, 16'd0, 1'b0, 4'd6);
        run_flow(5'd10, 5'd11, 1'b0, 16'd0, 4'd6, 1'b0, 5'd0, 32'd7, 32'd7, 1'b0, 16'd6, 0);
        chk("t5_rf0", rf[0], 32'd0);

        // 6: reset asserted in the middle of WB
        preload(5'd14, 32'h0000_0055);
        issue(5'd11, 5'd11, 5'd14, 16'd0, 1'b0, 4'd2);
        @(negedge clk);
        @(negedge clk);
        chk("t6_wb_rf_we_before_rst", bus.rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rf_we", bus.rf_we, 1'b0);
        chk("t6_rst_op_count", bus.op_count, 16'd0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("t6_rst_raddr1", bus.rf_raddr1, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rf14_kept", rf[14], 32'h0000_0055);
        chk("t6_cmd_ready", bus.cmd_ready, 1'b1);
        chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
        $display("reset during WB: rf[14]=0x%08h op_count=%0d t=%0t", rf[14], bus.op_count, $time);

        // recovery: SLT 3 < 3 = 0 into $t7
        preload(5'd15, 32'd9);
        issue(5'd11, 5'd11, 5'd15, 16'd0, 1'b0, 4'd7);
        run_flow(5'd11, 5'd11, 1'b0, 16'd0, 4'd7, 1'b1, 5'd15, 32'd0, 32'd0, 1'b0, 16'd1, 0);
        chk("t6_rf15", rf[15], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
